// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and helpers.
package fetch_pkg;

   localparam int unsigned PIX_W_DEF    = 8;
   localparam int unsigned WORD_PIX_DEF = 32;
   localparam int unsigned WORD_W       = WORD_PIX_DEF * PIX_W_DEF;

   // Pointer width for n entries, never less than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/fetch_cur_bank.sv
// Single-write / single-read synchronous RAM bank with registered read data.
module fetch_cur_bank #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 256
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   always_comb begin
      rdata_d = rdata_q;
      if (re_i) rdata_d = mem_q[raddr_i];
   end

   // Storage array carries no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_cur_rotbuf.sv
// Rotating current-LCU buffer: one bank loads while NUM_CONS consumers read
// older LCUs; every start_i rotates the bank-to-role mapping by one.
module fetch_cur_rotbuf
   import fetch_pkg::*;
#(
   parameter int unsigned NUM_CONS = 2,
   parameter int unsigned PIX_W    = PIX_W_DEF,
   parameter int unsigned WORD_PIX = WORD_PIX_DEF,
   parameter int unsigned ADDR_W   = 6
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  start_i,
   input  logic                                  load_valid_i,
   input  logic [ADDR_W-1:0]                     load_addr_i,
   input  logic [WORD_PIX*PIX_W-1:0]             load_data_i,
   input  logic                                  load_done_i,
   input  logic [NUM_CONS-1:0]                   rd_en_i,
   input  logic [NUM_CONS*ADDR_W-1:0]            rd_addr_i,
   output logic [NUM_CONS*WORD_PIX*PIX_W-1:0]    rd_data_o,
   output logic [NUM_CONS-1:0]                   cons_vld_o,
   output logic [ADDR_W:0]                       wr_cnt_o,
   output logic                                  underrun_o,
   output logic                                  late_wr_o,
   output logic [clog2(NUM_CONS+1)-1:0]          wr_ptr_o
);

   localparam int unsigned NB     = NUM_CONS + 1;
   localparam int unsigned PTR_W  = clog2(NB);
   localparam int unsigned DATA_W = WORD_PIX * PIX_W;
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   // Bank read by consumer k: (ptr - 1 - k) mod NB.
   function automatic logic [PTR_W-1:0] cons_bank(input logic [PTR_W-1:0] ptr,
                                                  input int unsigned    k);
      int unsigned b;
      b = (32'(ptr) + NB - 1 - k) % NB;
      return PTR_W'(b);
   endfunction

   logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
   logic [NB-1:0]     bank_vld_d, bank_vld_q;
   logic              load_done_d, load_done_q;
   logic [CNT_W-1:0]  wr_cnt_d, wr_cnt_q;
   logic              underrun_d, underrun_q;
   logic              late_wr_d, late_wr_q;
   logic [NUM_CONS-1:0] cons_vld_d, cons_vld_q;
   logic [NUM_CONS-1:0] rd_pend_d, rd_pend_q;
   logic [PTR_W-1:0]  rd_sel_d  [NUM_CONS];
   logic [PTR_W-1:0]  rd_sel_q  [NUM_CONS];
   logic [DATA_W-1:0] rd_hold_d [NUM_CONS];
   logic [DATA_W-1:0] rd_hold_q [NUM_CONS];

   logic [PTR_W-1:0]  rd_bank   [NUM_CONS];
   logic [NB-1:0]     bank_we;
   logic [NB-1:0]     bank_re;
   logic [ADDR_W-1:0] bank_raddr [NB];
   logic [DATA_W-1:0] bank_rdata [NB];
   logic              wr_acc;
   logic              slot_ok;

   assign wr_acc  = load_valid_i & ~load_done_q;
   assign slot_ok = load_done_q | load_done_i;

   // Route each consumer's read request to the bank it currently owns.
   always_comb begin
      bank_re = '0;
      for (int unsigned b = 0; b < NB; b++) bank_raddr[b] = '0;
      for (int unsigned k = 0; k < NUM_CONS; k++) begin
         rd_bank[k]             = cons_bank(wr_ptr_q, k);
         bank_re[rd_bank[k]]    = rd_en_i[k];
         bank_raddr[rd_bank[k]] = rd_addr_i[k*ADDR_W +: ADDR_W];
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      assign bank_we[b] = wr_acc & (wr_ptr_q == PTR_W'(b));
      fetch_cur_bank #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk     (clk),
         .we_i    (bank_we[b]),
         .waddr_i (load_addr_i),
         .wdata_i (load_data_i),
         .re_i    (bank_re[b]),
         .raddr_i (bank_raddr[b]),
         .rdata_o (bank_rdata[b])
      );
   end

   // Slot bookkeeping, rotation and read-return tracking.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      bank_vld_d  = bank_vld_q;
      load_done_d = slot_ok;
      wr_cnt_d    = wr_cnt_q;
      underrun_d  = start_i & ~slot_ok;
      late_wr_d   = load_valid_i & load_done_q;
      cons_vld_d  = cons_vld_q;
      rd_pend_d   = rd_en_i;

      if (wr_acc && (wr_cnt_q != CNT_W'(DEPTH))) wr_cnt_d = wr_cnt_q + CNT_W'(1);

      if (start_i) begin
         bank_vld_d[wr_ptr_q] = slot_ok;
         wr_cnt_d             = '0;
         load_done_d          = 1'b0;
         wr_ptr_d             = (wr_ptr_q == PTR_W'(NB - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end

      for (int unsigned k = 0; k < NUM_CONS; k++) begin
         cons_vld_d[k] = bank_vld_d[cons_bank(wr_ptr_d, k)];
         rd_sel_d[k]   = rd_en_i[k] ? rd_bank[k] : rd_sel_q[k];
         rd_hold_d[k]  = rd_pend_q[k] ? bank_rdata[rd_sel_q[k]] : rd_hold_q[k];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         bank_vld_q  <= '0;
         load_done_q <= 1'b0;
         wr_cnt_q    <= '0;
         underrun_q  <= 1'b0;
         late_wr_q   <= 1'b0;
         cons_vld_q  <= '0;
         rd_pend_q   <= '0;
         for (int unsigned k = 0; k < NUM_CONS; k++) begin
            rd_sel_q[k]  <= '0;
            rd_hold_q[k] <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         bank_vld_q  <= bank_vld_d;
         load_done_q <= load_done_d;
         wr_cnt_q    <= wr_cnt_d;
         underrun_q  <= underrun_d;
         late_wr_q   <= late_wr_d;
         cons_vld_q  <= cons_vld_d;
         rd_pend_q   <= rd_pend_d;
         for (int unsigned k = 0; k < NUM_CONS; k++) begin
            rd_sel_q[k]  <= rd_sel_d[k];
            rd_hold_q[k] <= rd_hold_d[k];
         end
      end
   end

   // Fresh bank word on the cycle after a read, held copy otherwise.
   always_comb begin
      rd_data_o = '0;
      for (int unsigned k = 0; k < NUM_CONS; k++)
         rd_data_o[k*DATA_W +: DATA_W] = rd_pend_q[k] ? bank_rdata[rd_sel_q[k]] : rd_hold_q[k];
   end

   assign wr_ptr_o   = wr_ptr_q;
   assign cons_vld_o = cons_vld_q;
   assign wr_cnt_o   = wr_cnt_q;
   assign underrun_o = underrun_q;
   assign late_wr_o  = late_wr_q;

endmodule

// File: tb/tb_fetch_cur_rotbuf.sv
// Directed + randomized bench for fetch_cur_rotbuf against an array-based slot model.
module tb_fetch_cur_rotbuf;
   import fetch_pkg::*;

   localparam int NC = 2;
   localparam int NB = NC + 1;
   localparam int AW = 6;
   localparam int DEP = 1 << AW;
   localparam int DW = WORD_W;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                start_i = 1'b0;
   logic                load_valid_i = 1'b0;
   logic [AW-1:0]       load_addr_i = '0;
   logic [DW-1:0]       load_data_i = '0;
   logic                load_done_i = 1'b0;
   logic [NC-1:0]       rd_en_i = '0;
   logic [NC*AW-1:0]    rd_addr_i = '0;
   logic [NC*DW-1:0]    rd_data_o;
   logic [NC-1:0]       cons_vld_o;
   logic [AW:0]         wr_cnt_o;
   logic                underrun_o;
   logic                late_wr_o;
   logic [1:0]          wr_ptr_o;

   fetch_cur_rotbuf #(.NUM_CONS(NC), .PIX_W(PIX_W_DEF), .WORD_PIX(WORD_PIX_DEF), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_i),
      .load_valid_i (load_valid_i),
      .load_addr_i  (load_addr_i),
      .load_data_i  (load_data_i),
      .load_done_i  (load_done_i),
      .rd_en_i      (rd_en_i),
      .rd_addr_i    (rd_addr_i),
      .rd_data_o    (rd_data_o),
      .cons_vld_o   (cons_vld_o),
      .wr_cnt_o     (wr_cnt_o),
      .underrun_o   (underrun_o),
      .late_wr_o    (late_wr_o),
      .wr_ptr_o     (wr_ptr_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: slot-level view of the buffer
   logic [DW-1:0] m_mem   [NB][DEP];
   bit            m_known [NB][DEP];
   bit            m_vld   [NB];
   int            m_ptr, m_cnt;
   bit            m_done, m_under, m_late;
   logic [DW-1:0] m_rd    [NC];
   bit            m_rd_kn [NC];

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic int owner(input int ptr, input int k);
      return (ptr + NB - 1 - k) % NB;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_cnt = 0; m_done = 0; m_under = 0; m_late = 0;
      for (int b = 0; b < NB; b++) begin
         m_vld[b] = 0;
         for (int a = 0; a < DEP; a++) m_known[b][a] = 0;
      end
      for (int k = 0; k < NC; k++) begin m_rd[k] = '0; m_rd_kn[k] = 1; end
   endtask

   task automatic check_all();
      logic [NC-1:0] ev;
      for (int k = 0; k < NC; k++) ev[k] = m_vld[owner(m_ptr, k)];
      chk("wr_ptr", DW'(wr_ptr_o), DW'(m_ptr));
      chk("cons_vld", DW'(cons_vld_o), DW'(ev));
      chk("wr_cnt", DW'(wr_cnt_o), DW'(m_cnt));
      chk("underrun", DW'(underrun_o), DW'(m_under));
      chk("late_wr", DW'(late_wr_o), DW'(m_late));
      for (int k = 0; k < NC; k++)
         if (m_rd_kn[k]) chk($sformatf("rd_data%0d", k), rd_data_o[k*DW +: DW], m_rd[k]);
   endtask

   // One clock of stimulus, model update and full output check.
   task automatic step(input bit st, input bit lv, input bit dn, input int la,
                       input bit [NC-1:0] re, input int ra0, input int ra1);
      logic [DW-1:0] d;
      int ra [NC];
      bit closing;
      d = rand_word();
      ra[0] = ra0; ra[1] = ra1;
      start_i = st; load_valid_i = lv; load_done_i = dn;
      load_addr_i = AW'(la); load_data_i = d; rd_en_i = re;
      rd_addr_i = {AW'(ra1), AW'(ra0)};
      @(posedge clk);
      for (int k = 0; k < NC; k++)
         if (re[k]) begin
            m_rd[k]    = m_mem[owner(m_ptr, k)][ra[k]];
            m_rd_kn[k] = m_known[owner(m_ptr, k)][ra[k]];
         end
      m_late = lv && m_done;
      if (lv && !m_done) begin
         m_mem[m_ptr][la]   = d;
         m_known[m_ptr][la] = 1;
         if (m_cnt < DEP) m_cnt++;
      end
      closing = m_done || dn;
      m_under = st && !closing;
      if (st) begin
         m_vld[m_ptr] = closing;
         m_ptr  = (m_ptr + 1) % NB;
         m_cnt  = 0;
         m_done = 0;
      end else m_done = closing;
      #1;
      start_i = 0; load_valid_i = 0; load_done_i = 0; rd_en_i = '0;
      check_all();
   endtask

   task automatic load_lcu(input int nwords);
      for (int a = 0; a < nwords; a++) step(0, 1, 0, a % DEP, 2'($urandom), $urandom_range(0, DEP-1), $urandom_range(0, DEP-1));
      step(0, 0, 1, 0, '0, 0, 0);
      step(1, 0, 0, 0, '0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;

      // First LCU with extra writes to exercise counter saturation
      for (int a = 0; a < DEP + 6; a++) step(0, 1, 0, a % DEP, '0, 0, 0);
      chk("wr_cnt_sat", DW'(wr_cnt_o), DW'(DEP));
      step(0, 0, 1, 0, '0, 0, 0);
      step(1, 0, 0, 0, '0, 0, 0);
      chk("ptr_after_lcu0", DW'(wr_ptr_o), DW'(1));
      chk("vld_after_lcu0", DW'(cons_vld_o), DW'(2'b01));
      step(0, 0, 0, 0, 2'b01, 5, 0);
      chk("c0_addr5", rd_data_o[DW-1:0], m_mem[0][5]);

      // Two more LCUs; last start wraps the pointer
      load_lcu(DEP);
      load_lcu(DEP);
      chk("ptr_wrap", DW'(wr_ptr_o), DW'(0));
      step(0, 0, 0, 0, 2'b11, 9, 17);
      chk("c0_lcu2", rd_data_o[DW-1:0], m_mem[2][9]);
      chk("c1_lcu1", rd_data_o[2*DW-1:DW], m_mem[1][17]);

      // Start with no load_done: underrun, slot left invalid
      step(0, 1, 0, 4, '0, 0, 0);
      step(1, 0, 0, 0, '0, 0, 0);
      chk("underrun_pulse", DW'(underrun_o), DW'(1));
      chk("vld_underrun", DW'(cons_vld_o[0]), DW'(0));
      step(0, 0, 0, 0, '0, 0, 0);

      // Late write after load_done is dropped
      step(0, 1, 0, 3, '0, 0, 0);
      step(0, 0, 1, 0, '0, 0, 0);
      step(0, 1, 0, 3, '0, 0, 0);
      chk("late_pulse", DW'(late_wr_o), DW'(1));
      chk("late_cnt", DW'(wr_cnt_o), DW'(1));
      step(1, 0, 0, 0, '0, 0, 0);
      step(0, 0, 0, 0, 2'b01, 3, 0);

      // start + write + done together
      step(0, 1, 0, 6, '0, 0, 0);
      step(1, 1, 1, 7, '0, 0, 0);
      chk("combo_no_under", DW'(underrun_o), DW'(0));
      chk("combo_cnt", DW'(wr_cnt_o), DW'(0));
      step(0, 0, 0, 0, 2'b01, 7, 0);

      // Read issued in the start cycle returns pre-rotation data
      load_lcu(12);
      step(1, 0, 1, 0, 2'b11, 3, 5);
      step(0, 0, 0, 0, '0, 0, 0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, DEP-1), 2'($urandom), $urandom_range(0, DEP-1), $urandom_range(0, DEP-1));

      // NB starts with no loads invalidate every consumer
      for (int i = 0; i < NB; i++) step(1, 0, 0, 0, '0, 0, 0);
      chk("all_invalid", DW'(cons_vld_o), DW'(0));

      // Reset in the middle of a load
      load_lcu(10);
      for (int a = 0; a < 5; a++) step(0, 1, 0, a, '0, 0, 0);
      load_valid_i = 1'b1; load_addr_i = 6'd5;
      #2 rstn = 1'b0;
      load_valid_i = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk);
      #1;
      check_all();
      rstn = 1'b1;
      step(0, 0, 0, 0, 2'b11, 1, 2);
      load_lcu(DEP);
      step(0, 0, 0, 0, 2'b01, 40, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
